pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 6: width of the multi-cycle length input and the internal down-counter.
REQ-002 Parameter STAT_W, default 16: width of the stall-cycle statistics counter.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 stallreq_from_if  input  1  fetch stage requests a stall (e.g. instruction memory not ready).
REQ-006 stallreq_from_id  input  1  decode stage requests a stall (load-use hazard).
REQ-007 ex_mc_start  input  1  EX has a multi-cycle op (div/madd) and requests sequencing; 1-cycle pulse.
REQ-008 ex_mc_cycles  input  CNT_W  number of cycles the op needs, sampled only with ex_mc_start.
REQ-009 ex_mc_cancel  input  1  abort the running multi-cycle op.
REQ-010 stall  output  6  per-stage hold vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop, 0 = NoStop.
REQ-011 mc_busy  output  1  multi-cycle sequencer not in IDLE.
REQ-012 mc_done  output  1  one-cycle pulse: multi-cycle result valid, EX may advance.
REQ-013 stall_cnt  output  STAT_W  number of cycles with stall[0]=1 since reset.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE + ex_mc_start: let N = ex_mc_cycles, with N=0 treated as 1; load counter with N-1; next state DONE if N=1, else RUN.
REQ-016 RUN: counter decrements each cycle; when counter = 1, next state DONE.
REQ-017 DONE: mc_done = 1 for exactly that cycle; next state IDLE unconditionally.
REQ-018 ex_mc_start in RUN or DONE SHALL be ignored; the counter and state are unaffected.
REQ-019 ex_mc_cancel in RUN or DONE: next state IDLE; in that cycle the EX stall source is deasserted and mc_done = 0.
REQ-020 ex_mc_cancel in IDLE has priority over a simultaneous ex_mc_start: no op is started.
REQ-021 EX stall source (combinational) = (IDLE & ex_mc_start & ~ex_mc_cancel) | (RUN & ~ex_mc_cancel); an op of N cycles therefore holds EX for exactly N cycles, and DONE follows.
REQ-022 stall is combinational, priority EX > ID > IF: EX source -> 6'b001111; else stallreq_from_id -> 6'b000111; else stallreq_from_if -> 6'b000011; else 6'b000000.
REQ-023 stall[5:4] SHALL always be 0.
REQ-024 mc_busy = (state != IDLE).
REQ-025 stall_cnt increments by 1 on each rising edge where stall[0] = 1, and saturates at all-ones with no wrap.
REQ-026 stallreq_from_id and stallreq_from_if SHALL NOT alter FSM state or the counter.

Reset
REQ-027 While rst = 0, asynchronously: state = IDLE, counter = 0, stall_cnt = 0.
REQ-028 While rst = 0: stall = 6'b000000, mc_busy = 0, mc_done = 0, regardless of other inputs.
REQ-029 Reset asserted mid-operation (RUN/DONE) SHALL abort the op immediately, with no mc_done pulse afterward.
REQ-030 After rst rises, the first rising edge SHALL behave as IDLE.

Verification
REQ-031 ex_mc_start, ex_mc_cycles = 3 at cycle T -> stall = 001111 at T, T+1, T+2; mc_done = 1 and stall = 000000 at T+3; mc_busy = 0 at T+4.
REQ-032 ex_mc_cycles = 0 and ex_mc_cycles = 1 -> stall = 001111 for exactly one cycle, then the DONE cycle with mc_done = 1.
REQ-033 stallreq_from_id = 1 and stallreq_from_if = 1 with no op -> stall = 000111; ID only -> 000111; IF only -> 000011; during RUN with both asserted -> 001111.
REQ-034 ex_mc_cycles = 10, ex_mc_cancel at the 4th RUN cycle -> stall = 000000 in that cycle, never mc_done, IDLE next cycle; a second ex_mc_start during RUN -> ignored, original length kept.
REQ-035 rst pulled low during RUN -> outputs zero immediately with no clock edge; after release, a new op of N = 2 sequences correctly.
REQ-036 With STAT_W = 4, hold stallreq_from_if for 20 cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: merges IF/ID stall requests with a multi-cycle EX
// sequencer (IDLE/RUN/DONE) into a per-stage hold vector, and counts stalled cycles.
module pipe_ctrl #(
    parameter int CNT_W  = 6,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_from_if,
    input  logic              stallreq_from_id,
    input  logic              ex_mc_start,
    input  logic [CNT_W-1:0]  ex_mc_cycles,
    input  logic              ex_mc_cancel,
    output logic [5:0]        stall,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [STAT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_ONE  = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [5:0]        STALL_EX  = 6'b001111;
    localparam logic [5:0]        STALL_ID  = 6'b000111;
    localparam logic [5:0]        STALL_IF  = 6'b000011;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   n_eff;
    logic               ex_stall;

    // A zero-length request still needs one EX cycle to hand its result over.
    assign n_eff = (ex_mc_cycles == '0) ? CNT_ONE : ex_mc_cycles;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ex_stall = 1'b0;
        mc_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_mc_start && !ex_mc_cancel) begin
                    ex_stall = 1'b1;
                    cnt_d    = n_eff - CNT_ONE;
                    state_d  = (n_eff == CNT_ONE) ? DONE : RUN;
                end
            end
            RUN: begin
                if (ex_mc_cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    ex_stall = 1'b1;
                    cnt_d    = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = DONE;
                end
            end
            DONE: begin
                mc_done = !ex_mc_cancel;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset forces the hold vector low even though its sources are combinational inputs.
    always_comb begin
        stall = 6'b000000;
        if (rst) begin
            if (ex_stall)              stall = STALL_EX;
            else if (stallreq_from_id) stall = STALL_ID;
            else if (stallreq_from_if) stall = STALL_IF;
        end
    end

    assign mc_busy = (state_q != IDLE);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall[0] && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_ONE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a schedule-based model (start cycle + length) checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_if, req_id, start, cancel;
    logic [5:0]  cycles;
    logic [5:0]  stall, stall4;
    logic        busy, busy4, done, done4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int total = 0;
    int bad   = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .stallreq_from_if(req_if), .stallreq_from_id(req_id),
        .ex_mc_start(start), .ex_mc_cycles(cycles), .ex_mc_cancel(cancel),
        .stall(stall), .mc_busy(busy), .mc_done(done), .stall_cnt(cnt)
    );

    pipe_ctrl #(.CNT_W(6), .STAT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stallreq_from_if(req_if), .stallreq_from_id(req_id),
        .ex_mc_start(start), .ex_mc_cycles(cycles), .ex_mc_cancel(cancel),
        .stall(stall4), .mc_busy(busy4), .mc_done(done4), .stall_cnt(cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: an op is an interval in cycle numbers. It starts at cycle s with
    // length N and completes at cycle done_at = s + max(N,1).
    bit m_active  = 1'b0;
    int m_done_at = 0;
    int m_cyc     = 0;
    int m_cnt     = 0;
    int m_cnt4    = 0;

    function automatic bit exp_ex();
        if (!rst) return 1'b0;
        if (m_active) return (m_cyc < m_done_at) && !cancel;
        return start && !cancel;
    endfunction

    function automatic logic [5:0] exp_stall();
        if (!rst)    return 6'b000000;
        if (exp_ex()) return 6'b001111;
        if (req_id)  return 6'b000111;
        if (req_if)  return 6'b000011;
        return 6'b000000;
    endfunction

    function automatic bit exp_done();
        return rst && m_active && (m_cyc == m_done_at) && !cancel;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_cnt4   <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_active) begin
                if (cancel || m_cyc == m_done_at) m_active <= 1'b0;
            end else if (start && !cancel) begin
                m_active  <= 1'b1;
                m_done_at <= m_cyc + ((cycles == 0) ? 1 : int'(cycles));
            end
            if (exp_stall() & 6'b000001) begin
                if (m_cnt < 65535) m_cnt <= m_cnt + 1;
                if (m_cnt4 < 15)   m_cnt4 <= m_cnt4 + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_stall",   32'(stall),  32'(exp_stall()));
        check("cmp_stall4",  32'(stall4), 32'(exp_stall()));
        check("cmp_busy",    32'(busy),   32'(rst && m_active));
        check("cmp_done",    32'(done),   32'(exp_done()));
        check("cmp_cnt",     32'(cnt),    32'(m_cnt));
        check("cmp_cnt4",    32'(cnt4),   32'(m_cnt4));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #2;
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; cycles = 6'd3; req_id = 1'b1; req_if = 1'b1; cancel = 1'b0;
        #3;
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_cnt",   32'(cnt),   32'h0);
        step();
        start = 1'b0; req_id = 1'b0; req_if = 1'b0;
        step();
        rst = 1'b1;

        // N=3 starting in the first cycle after reset release
        start = 1'b1; cycles = 6'd3; probe();
        check("n3_t0_stall", 32'(stall), 32'h0f);
        check("n3_t0_busy",  32'(busy),  32'h0);
        step(); start = 1'b0; probe();
        check("n3_t1_stall", 32'(stall), 32'h0f);
        check("n3_t1_busy",  32'(busy),  32'h1);
        step(); probe();
        check("n3_t2_stall", 32'(stall), 32'h0f);
        step(); probe();
        check("n3_t3_done",  32'(done),  32'h1);
        check("n3_t3_stall", 32'(stall), 32'h0);
        step(); probe();
        check("n3_t4_busy",  32'(busy),  32'h0);
        check("n3_t4_done",  32'(done),  32'h0);

        // N=0 and N=1 both give one stall cycle then DONE
        for (int n = 0; n < 2; n++) begin
            start = 1'b1; cycles = 6'(n); probe();
            check("n01_stall", 32'(stall), 32'h0f);
            step(); start = 1'b0; probe();
            check("n01_done",  32'(done),  32'h1);
            check("n01_stall_done", 32'(stall), 32'h0);
            step(); probe();
            check("n01_idle",  32'(busy),  32'h0);
        end

        // stall request priority
        req_id = 1'b1; req_if = 1'b1; probe();
        check("pri_both", 32'(stall), 32'h07);
        step(); req_if = 1'b0; probe();
        check("pri_id",   32'(stall), 32'h07);
        step(); req_id = 1'b0; req_if = 1'b1; probe();
        check("pri_if",   32'(stall), 32'h03);
        step(); req_if = 1'b0; probe();
        check("pri_none", 32'(stall), 32'h00);
        step(); req_id = 1'b1; req_if = 1'b1; start = 1'b1; cycles = 6'd4; probe();
        check("pri_ex_start", 32'(stall), 32'h0f);
        step(); start = 1'b0; probe();
        check("pri_ex_run",   32'(stall), 32'h0f);
        step(); step(); step(); probe();
        check("pri_done_id",  32'(stall), 32'h07);
        check("pri_done",     32'(done),  32'h1);
        step(); req_id = 1'b0; req_if = 1'b0;

        // N=10, ignored restart, cancel at the 4th RUN cycle
        start = 1'b1; cycles = 6'd10;
        step(); start = 1'b0;
        step(); start = 1'b1; cycles = 6'd2;
        step(); start = 1'b0;
        step(); cancel = 1'b1; probe();
        check("cxl_stall", 32'(stall), 32'h0);
        check("cxl_done",  32'(done),  32'h0);
        check("cxl_busy",  32'(busy),  32'h1);
        step(); cancel = 1'b0; probe();
        check("cxl_idle",  32'(busy),  32'h0);

        // N=4 with restart in RUN and in DONE, both ignored
        start = 1'b1; cycles = 6'd4;
        step(); cycles = 6'd1;
        step(); start = 1'b0;
        step(); probe();
        check("keep_len_t3", 32'(stall), 32'h0f);
        step(); start = 1'b1; cycles = 6'd2; probe();
        check("keep_len_done", 32'(done), 32'h1);
        step(); start = 1'b0; probe();
        check("done_start_ign", 32'(busy), 32'h0);

        // cancel during DONE, then cancel beating start in IDLE
        start = 1'b1; cycles = 6'd1;
        step(); start = 1'b0; cancel = 1'b1; probe();
        check("cxl_in_done", 32'(done), 32'h0);
        step(); cancel = 1'b0; start = 1'b1; cancel = 1'b1; probe();
        check("cxl_idle_stall", 32'(stall), 32'h0);
        step(); start = 1'b0; cancel = 1'b0; probe();
        check("cxl_idle_nostart", 32'(busy), 32'h0);

        // asynchronous reset in the middle of RUN
        start = 1'b1; cycles = 6'd6;
        step(); start = 1'b0;
        step(); req_if = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'h0);
        check("arst_busy",  32'(busy),  32'h0);
        check("arst_done",  32'(done),  32'h0);
        check("arst_cnt",   32'(cnt),   32'h0);
        step(); step(); req_if = 1'b0;
        rst = 1'b1; start = 1'b1; cycles = 6'd2; probe();
        check("post_t0_stall", 32'(stall), 32'h0f);
        step(); start = 1'b0; probe();
        check("post_t1_stall", 32'(stall), 32'h0f);
        check("post_t1_busy",  32'(busy),  32'h1);
        step(); probe();
        check("post_t2_done",  32'(done),  32'h1);
        step(); probe();
        check("post_t3_busy",  32'(busy),  32'h0);

        // statistics counter saturation on the narrow instance
        rst = 1'b0;
        step(); rst = 1'b1; req_if = 1'b1;
        repeat (10) step();
        check("sat_cnt4_10", 32'(cnt4), 32'd10);
        repeat (10) step();
        check("sat_cnt4_20", 32'(cnt4), 32'd15);
        check("sat_cnt_20",  32'(cnt),  32'd20);
        req_if = 1'b0;
        step();
        check("sat_cnt4_hold", 32'(cnt4), 32'd15);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
